// File: rtl/bit_serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin LSB first over WIDTH clocks using
// one borrow flop, with a self-sequencing FSM and a one-cycle done strobe.
module bit_serial_subtractor #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] z;
  logic [WIDTH-1:0] res;
  logic             br;
  logic [CNT_W-1:0] cnt;

  logic             d_c;
  logic             br_next_c;
  logic             last_c;

  // 1-bit full subtractor on the current LSBs
  always_comb begin
    d_c       = x[0] ^ z[0] ^ br;
    br_next_c = (~x[0] & z[0]) | (~(x[0] ^ z[0]) & br);
    last_c    = (cnt == CNT_W'(WIDTH - 1));
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_c) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Operand/result shift registers, counter and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x    <= '0;
      z    <= '0;
      res  <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      diff <= '0;
      bout <= 1'b0;
      ovf  <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            x    <= a;
            z    <= b;
            br   <= bin;
            cnt  <= '0;
            res  <= '0;
            busy <= 1'b1;
          end
        end
        SHIFT: begin
          x   <= {1'b0, x[WIDTH-1:1]};
          z   <= {1'b0, z[WIDTH-1:1]};
          res <= {d_c, res[WIDTH-1:1]};
          br  <= br_next_c;
          if (last_c) begin
            // br here is the borrow into the MSB
            diff <= {d_c, res[WIDTH-1:1]};
            bout <= br_next_c;
            ovf  <= br_next_c ^ br;
            done <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
        end
        default: begin
          done <= 1'b0;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Directed self-checking bench for bit_serial_subtractor at WIDTH=8.
module tb_bit_serial_subtractor;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic [7:0] diff;
  logic       bout;
  logic       ovf;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  bit_serial_subtractor #(.WIDTH(8), .CNT_W(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One operation with a 1-cycle start; optionally pokes start (with a=0,b=0) at negedge index poke_at
  task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_, input logic tbin,
                        input logic [7:0] ed, input logic eb, input logic eo, input int poke_at);
    int lat;
    int busy_n;
    int done_n;
    logic [7:0] prev;
    lat = 0; busy_n = 0; done_n = 0;
    @(negedge clk);
    prev  = diff;
    a     = ta;
    b     = tb_;
    bin   = tbin;
    start = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0) begin
        start = 1'b0;
        a = 8'hxx; b = 8'hxx; bin = 1'bx;
        check({tag, "_hold"}, {24'd0, diff}, {24'd0, prev});
      end
      if (i == poke_at) begin
        start = 1'b1; a = 8'h00; b = 8'h00; bin = 1'b0;
      end
      if (i == poke_at + 1) start = 1'b0;
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (lat == 0) begin
          lat = i + 1;
          check({tag, "_diff"}, {24'd0, diff}, {24'd0, ed});
          check({tag, "_bout"}, {31'd0, bout}, {31'd0, eb});
          check({tag, "_ovf"},  {31'd0, ovf},  {31'd0, eo});
        end
      end
      if (!busy && !done) break;
    end
    start = 1'b0;
    check({tag, "_latency"}, lat, 9);
    check({tag, "_busy_cycles"}, busy_n, 9);
    check({tag, "_done_cycles"}, done_n, 1);
  endtask

  logic [7:0] bb_a  [3] = '{8'h10, 8'h7F, 8'hC8};
  logic [7:0] bb_b  [3] = '{8'h20, 8'h80, 8'h32};
  logic       bb_bi [3] = '{1'b0, 1'b0, 1'b1};
  logic [7:0] bb_d  [3] = '{8'hF0, 8'hFF, 8'h95};
  logic       bb_bo [3] = '{1'b1, 1'b1, 1'b0};
  logic       bb_ov [3] = '{1'b0, 1'b1, 1'b0};

  initial begin
    int n_acc;
    int n_done;
    int last_done_t;
    int cyc;
    bit unstable;
    bit saw_done;
    rst = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_diff", {24'd0, diff}, 32'd0);
    check("rst_flags", {28'd0, bout, ovf, busy, done}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    run_op("basic",  8'd100, 8'd37,  1'b0, 8'd63,  1'b0, 1'b0, -1);
    run_op("neg",    8'h05,  8'h0A,  1'b0, 8'hFB,  1'b1, 1'b0, -1);
    run_op("ovf_a",  8'h80,  8'h01,  1'b0, 8'h7F,  1'b0, 1'b1, -1);
    run_op("ovf_b",  8'h7F,  8'hFF,  1'b0, 8'h80,  1'b1, 1'b1, -1);
    run_op("bin_a",  8'h00,  8'h00,  1'b1, 8'hFF,  1'b1, 1'b0, -1);
    run_op("bin_b",  8'hFF,  8'hFF,  1'b1, 8'hFF,  1'b1, 1'b0, -1);
    run_op("ignore", 8'h55,  8'h11,  1'b0, 8'h44,  1'b0, 1'b0, 3);

    // Async reset after the 4th SHIFT edge of a new operation
    @(negedge clk);
    a = 8'h80; b = 8'h01; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("arst_diff", {24'd0, diff}, 32'd0);
    check("arst_flags", {28'd0, bout, ovf, busy, done}, 32'd0);
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    rst = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("arst_no_done", {31'd0, saw_done}, 32'd0);

    // start held high: three back-to-back operations
    n_acc = 0; n_done = 0; last_done_t = 0; unstable = 1'b0;
    @(negedge clk);
    for (cyc = 0; cyc < 60; cyc++) begin
      if (done) begin
        if (n_done < 3) begin
          check($sformatf("b2b%0d_diff", n_done), {24'd0, diff}, {24'd0, bb_d[n_done]});
          check($sformatf("b2b%0d_flags", n_done), {30'd0, bout, ovf}, {30'd0, bb_bo[n_done], bb_ov[n_done]});
          if (n_done > 0) check($sformatf("b2b%0d_spacing", n_done), cyc - last_done_t, 10);
        end
        last_done_t = cyc;
        n_done++;
      end else if (n_done > 0 && n_done <= 3) begin
        if (diff !== bb_d[n_done-1] || bout !== bb_bo[n_done-1] || ovf !== bb_ov[n_done-1])
          unstable = 1'b1;
      end
      if (!busy) begin
        if (n_acc < 3) begin
          a = bb_a[n_acc]; b = bb_b[n_acc]; bin = bb_bi[n_acc]; start = 1'b1;
          n_acc++;
        end else begin
          start = 1'b0;
        end
      end
      if (n_done == 3 && !busy) break;
      @(negedge clk);
    end
    start = 1'b0;
    check("b2b_done_count", n_done, 3);
    check("b2b_stable", {31'd0, unstable}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bit_serial_subtractor.md
Name: bit_serial_subtractor

Overview:
- Companion to the team's bit-serial adder. Computes a - b - bin one bit per clock, LSB first, with a single borrow flip-flop and a 1-bit full subtractor.
- Parallel operands are loaded into shift registers, shifted out serially, and the difference is shifted back into a result register.
- Self-sequencing: an internal FSM and bit counter replace the external load timing. The block drives a one-cycle done strobe.
- Sits next to the adder in the serial ALU datapath. Used for SUB/CMP-style operations.

Parameters:
- WIDTH, 8, operand and result width in bits (2 to 32).
- CNT_W, 5, bit-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-low reset.
- start, input, 1, request; sampled only in IDLE.
- a, input, WIDTH, minuend; captured on the accepted start edge.
- b, input, WIDTH, subtrahend; captured on the accepted start edge.
- bin, input, 1, borrow-in; captured on the accepted start edge.
- diff, output, WIDTH, result a - b - bin mod 2^WIDTH.
- bout, output, 1, borrow out of the MSB (1 means unsigned a < b + bin).
- ovf, output, 1, signed two's-complement overflow.
- busy, output, 1, high from start acceptance through the DONE cycle.
- done, output, 1, one-cycle strobe; diff, bout and ovf are valid while it is high.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, counter=0, borrow FF=0, all shift registers=0.
  - diff=0, bout=0, ovf=0, busy=0, done=0.
  - Applies immediately, including mid-operation. The partial result is discarded and no done is produced.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, start=1 at an edge:
  - Load x<=a, z<=b, borrow<=bin, counter<=0.
  - Clear the result shift register.
  - busy<=1, go to SHIFT.
  - diff, bout and ovf stay at their old values until the new result commits at done.
- SHIFT, each edge:
  - d = x[0]^z[0]^br.
  - br_next = (~x[0]&z[0]) | (~(x[0]^z[0])&br).
  - Result register shifts right with d entering at the MSB. x and z shift right with zero fill. borrow<=br_next. counter++.
  - On the edge where counter==WIDTH-1 (the MSB bit):
    - Commit the final shifted value to diff and br_next to bout.
    - ovf <= br_next XOR (borrow into the MSB).
    - done<=1, go to DONE.
- DONE: lasts exactly one cycle with done=1 and busy=1. Next edge: done<=0, busy<=0, go to IDLE.
- Latency: the start edge plus WIDTH edges. done is high in the cycle following edge WIDTH after the start edge (9 edges for WIDTH=8).
- start handling:
  - start while busy (SHIFT or DONE) is ignored: no queuing and no effect on the operands in flight.
  - start held high continuously gives back-to-back operations: each IDLE cycle accepts a new one, so throughput is one result per WIDTH+2 cycles.
- Output holding: diff, bout and ovf hold their value from done until the next commit. Inputs a, b and bin are don't-care outside the accept edge.
- Wrap-around: the result is modulo 2^WIDTH. Borrow out of the MSB is reported only via bout and is never fed back.
- Counter never exceeds WIDTH-1 and is reset on each accept.

Test Plan:
- WIDTH=8, a=100, b=37, bin=0, 1-cycle start → done on the 9th edge after the start edge; diff=8'd63, bout=0, ovf=0. busy is high for exactly 9 cycles and done for exactly 1 cycle.
- a=8'h05, b=8'h0A, bin=0 → diff=8'hFB, bout=1, ovf=0.
- a=8'h80, b=8'h01, bin=0 → diff=8'h7F, bout=0, ovf=1. Then a=8'h7F, b=8'hFF → diff=8'h80, bout=1, ovf=1.
- a=8'h00, b=8'h00, bin=1 → diff=8'hFF, bout=1, ovf=0. Then a=8'hFF, b=8'hFF, bin=1 → diff=8'hFF, bout=1, ovf=0.
- Start a=8'h55, b=8'h11; pulse start again mid-SHIFT with a=8'h00 → second start ignored; diff=8'h44. Then assert rst=0 asynchronously after the 4th SHIFT edge of a new operation → all outputs 0 immediately, no done pulse.
- start tied high with 3 operand pairs changed at each accept → 3 done pulses spaced 10 cycles apart, each carrying the correct diff, bout and ovf; outputs are stable between pulses.
